// File: rtl/pipe_skid_reg.sv
// Purpose : elastic pipeline register with a 2-entry skid buffer (main + skid) and valid/ready on both sides.
// Latency : one cycle from acceptance into an empty stage to out_data/out_valid.
// Backpr. : in_ready depends only on registered state and flush, so a stalled consumer
//           throttles the producer one cycle late; the skid entry absorbs the in-flight item.
//
// Ports:
//   clk, reset (async, active-low), flush (sync clear of buffered entries)
//   in_valid / in_ready / in_data    : upstream handshake and payload
//   out_valid / out_ready / out_data : downstream handshake and registered payload
//   occupancy                        : number of buffered entries (0..2)

module pipe_skid_reg #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] main_q;
  logic [N-1:0] skid_q;
  logic         acc;
  logic         pop;

  // Handshakes are derived from state only on the input side; out_ready never
  // reaches in_ready.
  assign in_ready  = (state != FULL) && !flush;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;

  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      EMPTY:   occupancy = 2'd0;
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      // Only validity is cleared; payload registers keep their contents.
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state  <= BUSY;
            main_q <= in_data;
          end
        end
        BUSY: begin
          if (acc && pop) begin
            main_q <= in_data;
          end else if (acc) begin
            // Consumer stalled while a new item arrived: park it behind main.
            state  <= FULL;
            skid_q <= in_data;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move the stage.
          if (pop) begin
            state  <= BUSY;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
